// File: rtl/dec_stage.sv
// Multi-lane decode stage: per-lane decode, kill-after-illegal, intra-bundle RAW matrix, then a bundle FIFO.
// One cycle from push to output; in_ready_o drops only when the FIFO is full, independent of out_ready_i.

module decoder (
  input  logic [31:0] instr_i,
  output logic        illegal_inst_o,
  output logic        rd_v_o,
  output logic        rs1_v_o,
  output logic        rs2_v_o,
  output logic        rs2_is_immediat_o,
  output logic        is_store_o,
  output logic        is_load_o,
  output logic        is_branch_o,
  output logic        unsign_extension_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] immediat_o,
  output logic [2:0]  access_size_o,
  output logic [12:0] instr_type_o
);
  localparam int T_LUI = 0, T_AUIPC = 1, T_JAL = 2, T_JALR = 3, T_BRANCH = 4, T_LOAD = 5, T_STORE = 6;
  localparam int T_OPIMM = 7, T_OP = 8, T_FENCE = 9, T_SYSTEM = 10, T_CSR = 11, T_MULDIV = 12;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        legal;
  logic [2:0]  mem_size;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  // Access size in bytes: 1, 2 or 4.
  assign mem_size = (funct3[1:0] == 2'd0) ? 3'd1 : (funct3[1:0] == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    legal              = 1'b0;
    rd_v_o             = 1'b0;
    rs1_v_o            = 1'b0;
    rs2_v_o            = 1'b0;
    rs2_is_immediat_o  = 1'b0;
    is_store_o         = 1'b0;
    is_load_o          = 1'b0;
    is_branch_o        = 1'b0;
    unsign_extension_o = 1'b0;
    immediat_o         = '0;
    access_size_o      = '0;
    instr_type_o       = '0;
    rd_o               = instr_i[11:7];
    rs1_o              = instr_i[19:15];
    rs2_o              = instr_i[24:20];
    case (opcode)
      7'b0110111: begin
        legal = 1'b1; rd_v_o = 1'b1; immediat_o = imm_u; instr_type_o[T_LUI] = 1'b1;
      end
      7'b0010111: begin
        legal = 1'b1; rd_v_o = 1'b1; immediat_o = imm_u; instr_type_o[T_AUIPC] = 1'b1;
      end
      7'b1101111: begin
        legal = 1'b1; rd_v_o = 1'b1; immediat_o = imm_j; instr_type_o[T_JAL] = 1'b1;
      end
      7'b1100111: begin
        legal = (funct3 == 3'd0); rd_v_o = 1'b1; rs1_v_o = 1'b1; rs2_is_immediat_o = 1'b1;
        immediat_o = imm_i; instr_type_o[T_JALR] = 1'b1;
      end
      7'b1100011: begin
        legal = (funct3 != 3'd2) && (funct3 != 3'd3); rs1_v_o = 1'b1; rs2_v_o = 1'b1;
        is_branch_o = 1'b1; unsign_extension_o = funct3[1]; immediat_o = imm_b;
        instr_type_o[T_BRANCH] = 1'b1;
      end
      7'b0000011: begin
        legal = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        rd_v_o = 1'b1; rs1_v_o = 1'b1; rs2_is_immediat_o = 1'b1; is_load_o = 1'b1;
        unsign_extension_o = funct3[2]; immediat_o = imm_i; access_size_o = mem_size;
        instr_type_o[T_LOAD] = 1'b1;
      end
      7'b0100011: begin
        legal = (funct3 < 3'd3); rs1_v_o = 1'b1; rs2_v_o = 1'b1; is_store_o = 1'b1;
        immediat_o = imm_s; access_size_o = mem_size; instr_type_o[T_STORE] = 1'b1;
      end
      7'b0010011: begin
        // Shift-immediates constrain funct7; srai is the only non-zero encoding.
        legal = (funct3 == 3'd1) ? (funct7 == 7'd0) :
                (funct3 == 3'd5) ? (funct7 == 7'd0 || funct7 == 7'b0100000) : 1'b1;
        rd_v_o = 1'b1; rs1_v_o = 1'b1; rs2_is_immediat_o = 1'b1;
        unsign_extension_o = (funct3 == 3'd3); immediat_o = imm_i; instr_type_o[T_OPIMM] = 1'b1;
      end
      7'b0110011: begin
        rd_v_o = 1'b1; rs1_v_o = 1'b1; rs2_v_o = 1'b1;
        if (funct7 == 7'b0000001) begin
          legal = 1'b1; instr_type_o[T_MULDIV] = 1'b1;
          unsign_extension_o = (funct3 == 3'd3) || (funct3 == 3'd5) || (funct3 == 3'd7);
        end else begin
          legal = (funct7 == 7'd0) || (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5));
          unsign_extension_o = (funct3 == 3'd3); instr_type_o[T_OP] = 1'b1;
        end
      end
      7'b0001111: begin
        legal = (funct3 == 3'd0) || (funct3 == 3'd1); instr_type_o[T_FENCE] = 1'b1;
      end
      7'b1110011: begin
        if (funct3 == 3'd0) begin
          legal = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073);
          instr_type_o[T_SYSTEM] = 1'b1;
        end else begin
          // CSR ops; the immediate forms carry zimm in the rs1 field.
          legal = (funct3 != 3'd4); rd_v_o = 1'b1; rs1_v_o = !funct3[2];
          rs2_is_immediat_o = funct3[2]; immediat_o = {20'b0, instr_i[31:20]};
          instr_type_o[T_CSR] = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      rd_v_o             = 1'b0;
      rs1_v_o            = 1'b0;
      rs2_v_o            = 1'b0;
      rs2_is_immediat_o  = 1'b0;
      is_store_o         = 1'b0;
      is_load_o          = 1'b0;
      is_branch_o        = 1'b0;
      unsign_extension_o = 1'b0;
      immediat_o         = '0;
      access_size_o      = '0;
      instr_type_o       = '0;
    end
  end

  assign illegal_inst_o = !legal;
endmodule

module dec_stage #(
  parameter int NLANES    = 2,
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [NLANES-1:0]              in_lane_v_i,
  input  logic [NLANES*XLEN-1:0]         instr_i,
  input  logic [NLANES*XLEN-1:0]         pc_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [NLANES-1:0]              out_lane_v_o,
  output logic [NLANES*XLEN-1:0]         out_pc_o,
  output logic [NLANES-1:0]              illegal_inst_o,
  output logic [NLANES-1:0]              rd_v_o,
  output logic [NLANES-1:0]              rs1_v_o,
  output logic [NLANES-1:0]              rs2_v_o,
  output logic [NLANES-1:0]              rs2_is_immediat_o,
  output logic [NLANES-1:0]              is_store_o,
  output logic [NLANES-1:0]              is_load_o,
  output logic [NLANES-1:0]              is_branch_o,
  output logic [NLANES-1:0]              unsign_extension_o,
  output logic [NLANES*5-1:0]            rd_o,
  output logic [NLANES*5-1:0]            rs1_o,
  output logic [NLANES*5-1:0]            rs2_o,
  output logic [NLANES*32-1:0]           immediat_o,
  output logic [NLANES*3-1:0]            access_size_o,
  output logic [NLANES*13-1:0]           instr_type_o,
  output logic [NLANES*NLANES-1:0]       raw_dep_o,
  output logic [$clog2(BUF_DEPTH):0]     occupancy_o
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            vld;
    logic            illegal;
    logic            rd_v;
    logic            rs1_v;
    logic            rs2_v;
    logic            rs2_imm;
    logic            store;
    logic            load;
    logic            branch;
    logic            unsign;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [2:0]      size;
    logic [12:0]     itype;
    logic [XLEN-1:0] pc;
  } lane_t;

  typedef struct packed {
    lane_t [NLANES-1:0]         lane;
    logic [NLANES*NLANES-1:0]   raw;
  } entry_t;

  lane_t   dec [NLANES];
  entry_t  entry_in;
  logic    seen_ill;

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    logic        ill, rdv, rs1v, rs2v, rs2i, st, ld, br, uns;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [2:0]  size;
    logic [12:0] itype;

    decoder u_dec (
      .instr_i            (instr_i[l*XLEN +: 32]),
      .illegal_inst_o     (ill),
      .rd_v_o             (rdv),
      .rs1_v_o            (rs1v),
      .rs2_v_o            (rs2v),
      .rs2_is_immediat_o  (rs2i),
      .is_store_o         (st),
      .is_load_o          (ld),
      .is_branch_o        (br),
      .unsign_extension_o (uns),
      .rd_o               (rd),
      .rs1_o              (rs1),
      .rs2_o              (rs2),
      .immediat_o         (imm),
      .access_size_o      (size),
      .instr_type_o       (itype)
    );

    assign dec[l] = '{vld: in_lane_v_i[l], illegal: ill, rd_v: rdv, rs1_v: rs1v, rs2_v: rs2v,
                      rs2_imm: rs2i, store: st, load: ld, branch: br, unsign: uns, rd: rd,
                      rs1: rs1, rs2: rs2, imm: imm, size: size, itype: itype,
                      pc: pc_i[l*XLEN +: XLEN]};
  end

  // The first valid illegal lane survives as the trap carrier; everything younger dies.
  always_comb begin
    entry_in = '0;
    seen_ill = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      entry_in.lane[l]         = dec[l];
      entry_in.lane[l].vld     = dec[l].vld && !seen_ill;
      entry_in.lane[l].illegal = dec[l].vld && dec[l].illegal && !seen_ill;
      if (dec[l].vld && dec[l].illegal) seen_ill = 1'b1;
    end
    for (int j = 1; j < NLANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (entry_in.lane[i].vld && entry_in.lane[j].vld &&
            entry_in.lane[i].rd_v && (entry_in.lane[i].rd != 5'd0) &&
            ((entry_in.lane[j].rs1_v && (entry_in.lane[j].rs1 == entry_in.lane[i].rd)) ||
             (entry_in.lane[j].rs2_v && (entry_in.lane[j].rs2 == entry_in.lane[i].rd))))
          entry_in.raw[j*NLANES+i] = 1'b1;
      end
    end
  end

  entry_t           mem_q [BUF_DEPTH];
  entry_t           mem_d [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = !reset && (count_q != CW'(BUF_DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int e = 0; e < BUF_DEPTH; e++) mem_q[e] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  entry_t head;
  assign head        = mem_q[rd_ptr_q];
  assign raw_dep_o   = head.raw;
  assign occupancy_o = count_q;

  always_comb begin
    out_lane_v_o       = '0;
    out_pc_o           = '0;
    illegal_inst_o     = '0;
    rd_v_o             = '0;
    rs1_v_o            = '0;
    rs2_v_o            = '0;
    rs2_is_immediat_o  = '0;
    is_store_o         = '0;
    is_load_o          = '0;
    is_branch_o        = '0;
    unsign_extension_o = '0;
    rd_o               = '0;
    rs1_o              = '0;
    rs2_o              = '0;
    immediat_o         = '0;
    access_size_o      = '0;
    instr_type_o       = '0;
    for (int l = 0; l < NLANES; l++) begin
      out_lane_v_o[l]          = head.lane[l].vld;
      out_pc_o[l*XLEN +: XLEN] = head.lane[l].pc;
      illegal_inst_o[l]        = head.lane[l].illegal;
      rd_v_o[l]                = head.lane[l].rd_v;
      rs1_v_o[l]               = head.lane[l].rs1_v;
      rs2_v_o[l]               = head.lane[l].rs2_v;
      rs2_is_immediat_o[l]     = head.lane[l].rs2_imm;
      is_store_o[l]            = head.lane[l].store;
      is_load_o[l]             = head.lane[l].load;
      is_branch_o[l]           = head.lane[l].branch;
      unsign_extension_o[l]    = head.lane[l].unsign;
      rd_o[l*5 +: 5]           = head.lane[l].rd;
      rs1_o[l*5 +: 5]          = head.lane[l].rs1;
      rs2_o[l*5 +: 5]          = head.lane[l].rs2;
      immediat_o[l*32 +: 32]   = head.lane[l].imm;
      access_size_o[l*3 +: 3]  = head.lane[l].size;
      instr_type_o[l*13 +: 13] = head.lane[l].itype;
    end
  end
endmodule

// File: tb/tb_dec_stage.sv
// Scoreboard bench for dec_stage with NLANES=2, XLEN=32, BUF_DEPTH=2.
module tb_dec_stage;
  localparam int NL = 2, XL = 32, BD = 2;

  logic            clk = 1'b0;
  logic            reset, flush_i, in_valid_i, out_ready_i;
  logic [NL-1:0]   in_lane_v_i;
  logic [NL*XL-1:0] instr_i, pc_i;
  logic            in_ready_o, out_valid_o;
  logic [NL-1:0]   out_lane_v_o, illegal_inst_o, rd_v_o, rs1_v_o, rs2_v_o, rs2_is_immediat_o;
  logic [NL-1:0]   is_store_o, is_load_o, is_branch_o, unsign_extension_o;
  logic [NL*XL-1:0] out_pc_o;
  logic [NL*5-1:0] rd_o, rs1_o, rs2_o;
  logic [NL*32-1:0] immediat_o;
  logic [NL*3-1:0] access_size_o;
  logic [NL*13-1:0] instr_type_o;
  logic [NL*NL-1:0] raw_dep_o;
  logic [$clog2(BD):0] occupancy_o;

  dec_stage #(.NLANES(NL), .XLEN(XL), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_lane_v_i(in_lane_v_i), .instr_i(instr_i), .pc_i(pc_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_lane_v_o(out_lane_v_o), .out_pc_o(out_pc_o),
    .illegal_inst_o(illegal_inst_o), .rd_v_o(rd_v_o), .rs1_v_o(rs1_v_o), .rs2_v_o(rs2_v_o),
    .rs2_is_immediat_o(rs2_is_immediat_o), .is_store_o(is_store_o), .is_load_o(is_load_o),
    .is_branch_o(is_branch_o), .unsign_extension_o(unsign_extension_o), .rd_o(rd_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .immediat_o(immediat_o), .access_size_o(access_size_o),
    .instr_type_o(instr_type_o), .raw_dep_o(raw_dep_o), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI5 = 32'h0010_0293;  // addi x5,x0,1
  localparam logic [31:0] ADD6  = 32'h0052_8333;  // add  x6,x5,x5
  localparam logic [31:0] ILL   = 32'h0000_0000;

  int total = 0, bad = 0;
  logic [76:0] sb_q[$];
  logic [76:0] exp_v;
  logic [76:0] obs;
  assign obs = {out_lane_v_o, illegal_inst_o, raw_dep_o, rd_o[4:0], out_pc_o};

  function automatic logic [76:0] mk(input logic [1:0] m, input logic [1:0] il,
                                     input logic [3:0] raw, input logic [4:0] rd0,
                                     input logic [31:0] pc0);
    return {m, il, raw, rd0, pc0 + 32'd4, pc0};
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [31:0] pc0);
    in_valid_i  = v;
    in_lane_v_i = m;
    instr_i     = {i1, i0};
    pc_i        = {pc0 + 32'd4, pc0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    tick;
    total++;
    if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", in_ready_o); end
    tick;
    reset = 1'b0;
    #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_release: got %b want 1", in_ready_o); end
    total++;
    if ({out_valid_o, occupancy_o} !== 3'b000) begin
      bad++; $display("FAIL reset_state: valid/occ got %b want 000", {out_valid_o, occupancy_o});
    end
    total++;
    if ({out_lane_v_o, out_pc_o, rd_o, immediat_o, raw_dep_o, illegal_inst_o, instr_type_o} !== '0) begin
      bad++; $display("FAIL reset_data: data outputs not zero, got %h", obs);
    end
  endtask

  task automatic test_single;
    out_ready_i = 1'b0;
    drive(1'b1, 2'b11, ADDI5, ADD6, 32'h100);
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_no_bypass: got %b want 0", out_valid_o); end
    if (in_valid_i && in_ready_o && !flush_i) sb_q.push_back(mk(2'b11, 2'b00, 4'b0100, 5'd5, 32'h100));
    tick;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    total++;
    if ({out_valid_o, occupancy_o} !== 3'b101) begin
      bad++; $display("FAIL single_latency: valid/occ got %b want 101", {out_valid_o, occupancy_o});
    end
    total++;
    if ({immediat_o[31:0], rs2_is_immediat_o} !== {32'd1, 2'b01}) begin
      bad++; $display("FAIL single_decode: imm0/rs2imm got %h/%b want 1/01", immediat_o[31:0], rs2_is_immediat_o);
    end
    out_ready_i = 1'b1;
    if (out_valid_o && out_ready_i) begin
      exp_v = 'x; if (sb_q.size() > 0) exp_v = sb_q.pop_front();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL single_pop: got %h want %h", obs, exp_v); end
    end
    tick;
    total++;
    if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", out_valid_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_illegal;
    logic [31:0] i0s [3] = '{ILL, ADDI5, ILL};
    logic [31:0] i1s [3] = '{ADD6, ILL, ILL};
    logic [1:0]  ms  [3] = '{2'b11, 2'b11, 2'b00};
    logic [76:0] ex  [3];
    ex[0] = mk(2'b01, 2'b01, 4'b0000, 5'd0, 32'h500);
    ex[1] = mk(2'b11, 2'b10, 4'b0000, 5'd5, 32'h510);
    ex[2] = mk(2'b00, 2'b00, 4'b0000, 5'd0, 32'h520);
    out_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, ms[c], i0s[c], i1s[c], 32'h500 + 32'(c) * 32'h10);
      else drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
      if (out_valid_o && out_ready_i) begin
        exp_v = 'x; if (sb_q.size() > 0) exp_v = sb_q.pop_front();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL illegal_pop: got %h want %h", obs, exp_v); end
      end
      if (in_valid_i && in_ready_o && !flush_i) sb_q.push_back(ex[c]);
      tick;
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL illegal_timeout: %0d bundles left, want 0", sb_q.size()); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_backpressure;
    int n = 0;
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'b11, ADDI5, ADD6, 32'h200 + 32'(n) * 32'h10);
      if (c == 2) begin
        total++;
        if ({in_ready_o, occupancy_o} !== 3'b010) begin
          bad++; $display("FAIL bp_full: ready/occ got %b want 010", {in_ready_o, occupancy_o});
        end
      end
      if (in_valid_i && in_ready_o && !flush_i) begin
        sb_q.push_back(mk(2'b11, 2'b00, 4'b0100, 5'd5, 32'h200 + 32'(n) * 32'h10));
        n++;
      end
      tick;
    end
    out_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (n < 3) drive(1'b1, 2'b11, ADDI5, ADD6, 32'h200 + 32'(n) * 32'h10);
      else drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
      if (out_valid_o && out_ready_i) begin
        exp_v = 'x; if (sb_q.size() > 0) exp_v = sb_q.pop_front();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL bp_order: got %h want %h", obs, exp_v); end
      end
      if (in_valid_i && in_ready_o && !flush_i) begin
        sb_q.push_back(mk(2'b11, 2'b00, 4'b0100, 5'd5, 32'h200 + 32'(n) * 32'h10));
        n++;
      end
      tick;
    end
    total++;
    if (sb_q.size() != 0 || n != 3) begin
      bad++; $display("FAIL bp_timeout: left=%0d pushed=%0d want 0/3", sb_q.size(), n);
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  m;
    logic        ev;
    out_ready_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ev = (i % 2 == 0);
      m  = (i % 3 == 2) ? 2'b10 : 2'b11;
      if (i <= 10) begin
        if (ev) drive(1'b1, m, ADDI5, ADD6, 32'h1000 + 32'(i) * 32'h10);
        else    drive(1'b1, m, ADD6, ADDI5, 32'h1000 + 32'(i) * 32'h10);
      end else drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
      if (i >= 1 && i <= 10) begin
        total++;
        if (occupancy_o !== 2'd1) begin bad++; $display("FAIL b2b_occ: got %0d want 1", occupancy_o); end
      end
      if (out_valid_o && out_ready_i) begin
        exp_v = 'x; if (sb_q.size() > 0) exp_v = sb_q.pop_front();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_order: got %h want %h", obs, exp_v); end
      end
      if (in_valid_i && in_ready_o && !flush_i)
        sb_q.push_back(mk(m, 2'b00, (ev && m == 2'b11) ? 4'b0100 : 4'b0000,
                          ev ? 5'd5 : 5'd6, 32'h1000 + 32'(i) * 32'h10));
      tick;
      out_ready_i = 1'b1;
    end
    total++;
    if (sb_q.size() != 0 || out_valid_o !== 1'b0) begin
      bad++; $display("FAIL b2b_timeout: left=%0d valid=%b want 0/0", sb_q.size(), out_valid_o);
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_flush;
    out_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 2'b11, ADDI5, ADD6, 32'h300 + 32'(c) * 32'h10);
      if (in_valid_i && in_ready_o && !flush_i) sb_q.push_back(mk(2'b11, 2'b00, 4'b0100, 5'd5, 32'h300 + 32'(c) * 32'h10));
      tick;
    end
    drive(1'b1, 2'b11, ADDI5, ADD6, 32'hDEAD_0000);
    flush_i = 1'b1;
    total++;
    if ({in_ready_o, occupancy_o} !== 3'b010) begin
      bad++; $display("FAIL flush_pre: ready/occ got %b want 010", {in_ready_o, occupancy_o});
    end
    tick;
    flush_i = 1'b0;
    sb_q.delete();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    total++;
    if ({out_valid_o, occupancy_o} !== 3'b000) begin
      bad++; $display("FAIL flush_empty: valid/occ got %b want 000", {out_valid_o, occupancy_o});
    end
    drive(1'b1, 2'b01, ADD6, ADDI5, 32'h400);
    if (in_valid_i && in_ready_o && !flush_i) sb_q.push_back(mk(2'b01, 2'b00, 4'b0000, 5'd6, 32'h400));
    tick;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    out_ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid_o && out_ready_i) begin
        exp_v = 'x; if (sb_q.size() > 0) exp_v = sb_q.pop_front();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL flush_after: got %h want %h", obs, exp_v); end
      end
      tick;
    end
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL flush_timeout: %0d left want 0", sb_q.size()); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset;
    drive(1'b1, 2'b11, ADDI5, ADD6, 32'h600);
    tick;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid_o, occupancy_o, out_lane_v_o, out_pc_o} !== '0) begin
      bad++; $display("FAIL mid_reset: valid=%b occ=%0d mask=%b pc=%h want all 0",
                      out_valid_o, occupancy_o, out_lane_v_o, out_pc_o);
    end
    sb_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
